lp_fifo_1c_dfx: RTL
===================

LP_FIFO_1C_DFX -- requirements
Module: lp_fifo_1c_dfx

Interface
- REQ-001 SHALL have parameter WIDTH, default 8, data word width, legal range 1..1024.
- REQ-002 SHALL have parameter DEPTH, default 8, word capacity, legal range 2..1024; non-power-of-2 values are legal.
- REQ-003 SHALL have parameter FWFT, default 0: 0 = standard read (data registered on pop); 1 = first-word fall-through.
- REQ-004 SHALL have parameter AF_FROM_TOP, default 1: 1 = af_level counts down from DEPTH; 0 = af_level is an absolute count.
- REQ-005 SHALL have parameter ERR_MODE, default 0: 0 = sticky error; 1 = one-cycle error pulse.
- REQ-006 SHALL define derived constant CNT_W = ceil(log2(DEPTH+1)).
- REQ-007 SHALL have the following ports (name, direction, width, meaning); the design uses one clock, and reset is asynchronous and active-low:
  - clk, in, 1, rising-edge clock.
  - rst_n, in, 1, asynchronous active-low reset.
  - init_n, in, 1, synchronous active-low clear/flush.
  - ae_level, in, CNT_W, almost-empty threshold.
  - af_level, in, CNT_W, almost-full threshold.
  - level_change, in, 1, capture ae_level/af_level this cycle.
  - push_n, in, 1, active-low write request.
  - data_in, in, WIDTH, write data.
  - pop_n, in, 1, active-low read request.
  - data_out, out, WIDTH, read data.
  - word_cnt, out, CNT_W, stored word count.
  - empty, out, 1, empty flag.
  - almost_empty, out, 1, almost-empty flag.
  - half_full, out, 1, half-full flag.
  - almost_full, out, 1, almost-full flag.
  - full, out, 1, full flag.
  - error, out, 1, overflow/underflow indication.

Function
- REQ-008 SHALL store words in a register array addressed by wr_ptr and rd_ptr, each wrapping from DEPTH-1 to 0.
- REQ-009 SHALL accept a push when push_n=0 and (full=0 or an accepted pop occurs in the same cycle); an accepted push writes data_in at wr_ptr and advances wr_ptr.
- REQ-010 SHALL accept a pop when pop_n=0 and empty=0; an accepted pop advances rd_ptr.
- REQ-011 SHALL update word_cnt on the same edge as each operation: +1 on push only, -1 on pop only, unchanged on both or neither; range 0..DEPTH.
- REQ-012 SHALL hold all of the following when both are requested at empty: push accepted, pop rejected, underflow flagged, word_cnt becomes 1.
- REQ-013 SHALL hold all of the following when both are requested at full: both accepted, word_cnt stays DEPTH, no error.
- REQ-014 SHALL derive the flags combinationally from registered word_cnt and registered thresholds, with no extra latency:
  - empty = (cnt==0).
  - full = (cnt==DEPTH).
  - half_full = (cnt >= (DEPTH+1)/2).
  - almost_empty = (cnt <= ae_reg).
  - almost_full = (cnt >= DEPTH-af_reg) when AF_FROM_TOP=1, else (cnt >= af_reg).
- REQ-015 SHALL load ae_reg and af_reg from ae_level and af_level at a clock edge where level_change=1; otherwise they hold.
- REQ-016 SHALL saturate the AF_FROM_TOP=1 almost_full threshold at 0 when af_reg > DEPTH, with no wrap-around.
- REQ-017 SHALL, when FWFT=0, load data_out with mem[rd_ptr] on an accepted pop edge and hold it otherwise; read latency is 1 cycle after the pop edge.
- REQ-018 SHALL, when FWFT=1, drive data_out = mem[rd_ptr] continuously; it is valid whenever empty=0, and the first word of an empty FIFO is visible after the same edge that writes it.
- REQ-019 SHALL treat a push while full without an accepted pop as overflow: word discarded, pointers unchanged.
- REQ-020 SHALL treat a pop while empty as underflow: pointers and data_out unchanged.
- REQ-021 SHALL, when ERR_MODE=0, set error on the edge after overflow or underflow and hold it until reset or init_n=0.
- REQ-022 SHALL, when ERR_MODE=1, assert error for exactly the one cycle following each offending request.
- REQ-023 SHALL, on init_n=0 at an edge, clear pointers, word_cnt, data_out and error, ignore push/pop that cycle, and retain ae_reg/af_reg and memory contents.
- REQ-024 SHALL give init_n priority over push, pop and level_change when they coincide in the same cycle.

Reset
- REQ-025 SHALL, on rst_n=0 (asynchronous, any time, including mid-operation), immediately set all of the following: pointers=0, word_cnt=0, data_out=0, error=0, ae_reg=1, af_reg=1.
- REQ-026 SHALL present the following output values during and after reset: empty=1, almost_empty=1, half_full=0, almost_full=0, full=0.
- REQ-027 SHALL release reset synchronously: first operation accepted on the first rising clk edge with rst_n=1; memory contents are not reset.

Verification
- REQ-028 SHALL cover fill/drain: DEPTH=5, FWFT=0; push 1..5 -> full=1, word_cnt=5; 5 pops -> data_out 1,2,3,4,5, each 1 cycle after its pop edge; empty=1.
- REQ-029 SHALL cover wrap: DEPTH=5; push 3, pop 3, push 5, pop 5 -> data order preserved across pointer wrap 4->0, no error.
- REQ-030 SHALL cover FWFT: FWFT=1; push 0xA5 into empty FIFO -> data_out=0xA5 and empty=0 after that edge, with no pop.
- REQ-031 SHALL cover flags: DEPTH=8, AF_FROM_TOP=1, level_change with ae=2, af=2 -> almost_empty for cnt<=2, half_full at cnt=4, almost_full at cnt>=6.
- REQ-032 SHALL cover errors: ERR_MODE=0 push at full -> error=1 held through subsequent pops until init_n=0; ERR_MODE=1 pop at empty -> single-cycle error pulse.
- REQ-033 SHALL cover reset/flush mid-operation: cnt=3, assert rst_n=0 between edges -> outputs per REQ-025/026 immediately; repeat with init_n=0 -> cnt=0 and thresholds retained.

Source files
------------

// File: rtl/lp_fifo_1c_dfx.sv
// rtl/lp_fifo_1c_dfx.sv - single-clock FIFO with programmable flags, FWFT option and error reporting
module lp_fifo_1c_dfx #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 8,
  parameter int FWFT        = 0,
  parameter int AF_FROM_TOP = 1,
  parameter int ERR_MODE    = 0,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_n,
  input  logic [CNT_W-1:0] ae_level,
  input  logic [CNT_W-1:0] af_level,
  input  logic             level_change,
  input  logic             push_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop_n,
  output logic [WIDTH-1:0] data_out,
  output logic [CNT_W-1:0] word_cnt,
  output logic             empty,
  output logic             almost_empty,
  output logic             half_full,
  output logic             almost_full,
  output logic             full,
  output logic             error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((DEPTH + 1) / 2);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ae_reg;
  logic [CNT_W-1:0] af_reg;
  logic [CNT_W-1:0] af_thr;
  logic             err_q;
  logic             pop_ok;
  logic             push_ok;
  logic             overflow;
  logic             underflow;

  // A pop is only legal with data present; a push at full rides on a same-cycle pop.
  always_comb begin
    pop_ok    = !pop_n && (cnt != '0);
    push_ok   = !push_n && ((cnt != CNT_FULL) || pop_ok);
    overflow  = !push_n && (cnt == CNT_FULL) && !pop_ok;
    underflow = !pop_n && (cnt == '0);
  end

  // Counting down from the top saturates at zero rather than wrapping when af_reg exceeds DEPTH.
  always_comb begin
    af_thr = af_reg;
    if (AF_FROM_TOP != 0) begin
      if (af_reg > CNT_FULL) af_thr = '0;
      else                   af_thr = CNT_FULL - af_reg;
    end
  end

  always_comb begin
    word_cnt     = cnt;
    empty        = (cnt == '0);
    full         = (cnt == CNT_FULL);
    half_full    = (cnt >= CNT_HALF);
    almost_empty = (cnt <= ae_reg);
    almost_full  = (cnt >= af_thr);
    error        = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ae_reg <= CNT_W'(1);
      af_reg <= CNT_W'(1);
      err_q  <= 1'b0;
    end else if (!init_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      if (level_change) begin
        ae_reg <= ae_level;
        af_reg <= af_level;
      end
      if (push_ok) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (overflow || underflow) err_q <= 1'b1;
      else if (ERR_MODE != 0)    err_q <= 1'b0;
    end
  end

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clk) begin
    if (rst_n && init_n && push_ok) mem[wr_ptr] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       dout_q <= '0;
        else if (!init_n) dout_q <= '0;
        else if (pop_ok)  dout_q <= mem[rd_ptr];
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule
